// File: rtl/can_bit_stuffer.sv
// ---------------------------------------------------------------------------
// can_bit_stuffer
//
// Transmit-side CAN bit stuffer. It sits between the frame serializer and the
// bus driver. Unstuffed frame bits arrive over a valid/ready handshake into a
// one-entry holding buffer. One bit goes onto the TX line per bit-time
// strobe. While the stuffing window is open, a complementary stuff bit is
// inserted after every STUFF_LEN consecutive identical bits.
//
// Ports
//   clock        system clock, all state updates on the rising edge
//   reset        synchronous, active-high reset
//   tx_point     one-cycle strobe marking a bit boundary
//   stuff_en     stuffing window (SOF through last CRC bit)
//   bit_valid    serializer presents bit_in
//   bit_in       next unstuffed frame bit (0 = dominant)
//   bit_ready    holding buffer empty, a bit can be accepted
//   TX           registered serial line to the bus driver
//   stuff_bit    pulse: the TX value just driven is a stuff bit
//   underrun     pulse: tx_point arrived with nothing to send
//   run_len      current identical-bit run length
//   stuff_count  stuff bits inserted in the current window (saturating)
// ---------------------------------------------------------------------------
module can_bit_stuffer #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tx_point,
  input  logic             stuff_en,
  input  logic             bit_valid,
  input  logic             bit_in,
  output logic             bit_ready,
  output logic             TX,
  output logic             stuff_bit,
  output logic             underrun,
  output logic [2:0]       run_len,
  output logic [CNT_W-1:0] stuff_count
);

  localparam logic [2:0]       STUFF_LEN_W = 3'(STUFF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

  logic             buf_full_reg,      buf_full_next;
  logic             buf_bit_reg,       buf_bit_next;
  logic             last_bit_reg,      last_bit_next;
  logic             stuff_pending_reg, stuff_pending_next;
  logic             tx_reg,            tx_next;
  logic             stuff_bit_reg,     stuff_bit_next;
  logic             underrun_reg,      underrun_next;
  logic [2:0]       run_len_reg,       run_len_next;
  logic [CNT_W-1:0] stuff_count_reg,   stuff_count_next;
  logic             stuff_en_d_reg,    stuff_en_d_next;

  logic             fill;
  logic [2:0]       run_grown;
  logic [CNT_W-1:0] count_base;

  always_comb begin
    buf_full_next      = buf_full_reg;
    buf_bit_next       = buf_bit_reg;
    last_bit_next      = last_bit_reg;
    stuff_pending_next = stuff_pending_reg;
    tx_next            = tx_reg;
    stuff_bit_next     = 1'b0;
    underrun_next      = 1'b0;
    run_len_next       = run_len_reg;
    stuff_en_d_next    = stuff_en;
    run_grown          = 3'd1;

    // Fill only when empty. Consume only when full. So a refill can never
    // coincide with a consume, and the buffer needs no bypass path.
    fill = bit_valid & ~buf_full_reg;
    if (fill) begin
      buf_full_next = 1'b1;
      buf_bit_next  = bit_in;
    end

    // A new window starts the count from zero. An increment on that same
    // cycle builds on the cleared value.
    count_base       = (stuff_en & ~stuff_en_d_reg) ? '0 : stuff_count_reg;
    stuff_count_next = count_base;

    if (tx_point) begin
      if (stuff_pending_reg) begin
        // The stuff bit goes out even if the window has just closed. It is
        // the first bit of the next run. The buffered bit waits.
        tx_next            = ~last_bit_reg;
        last_bit_next      = ~last_bit_reg;
        run_len_next       = 3'd1;
        stuff_pending_next = 1'b0;
        stuff_bit_next     = 1'b1;
        if (count_base != CNT_MAX) begin
          stuff_count_next = count_base + 1'b1;
        end
      end else if (buf_full_reg) begin
        tx_next       = buf_bit_reg;
        buf_full_next = 1'b0;
        last_bit_next = buf_bit_reg;
        if (stuff_en) begin
          // run_len_reg is below STUFF_LEN here. At STUFF_LEN a stuff bit is
          // pending and takes the branch above, so the +1 cannot overflow.
          if ((run_len_reg != 3'd0) && (buf_bit_reg == last_bit_reg)) begin
            run_grown = run_len_reg + 3'd1;
          end
          run_len_next = run_grown;
          if (run_grown == STUFF_LEN_W) begin
            stuff_pending_next = 1'b1;
          end
        end else begin
          run_len_next = 3'd0;
        end
      end else begin
        // Nothing to send: idle recessive. The run is broken.
        tx_next       = 1'b1;
        underrun_next = 1'b1;
        last_bit_next = 1'b1;
        if (stuff_en) begin
          run_len_next = 3'd0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      buf_full_reg      <= 1'b0;
      buf_bit_reg       <= 1'b1;
      last_bit_reg      <= 1'b1;
      stuff_pending_reg <= 1'b0;
      tx_reg            <= 1'b1;
      stuff_bit_reg     <= 1'b0;
      underrun_reg      <= 1'b0;
      run_len_reg       <= 3'd0;
      stuff_count_reg   <= '0;
      stuff_en_d_reg    <= 1'b0;
    end else begin
      buf_full_reg      <= buf_full_next;
      buf_bit_reg       <= buf_bit_next;
      last_bit_reg      <= last_bit_next;
      stuff_pending_reg <= stuff_pending_next;
      tx_reg            <= tx_next;
      stuff_bit_reg     <= stuff_bit_next;
      underrun_reg      <= underrun_next;
      run_len_reg       <= run_len_next;
      stuff_count_reg   <= stuff_count_next;
      stuff_en_d_reg    <= stuff_en_d_next;
    end
  end

  assign bit_ready   = ~buf_full_reg;
  assign TX          = tx_reg;
  assign stuff_bit   = stuff_bit_reg;
  assign underrun    = underrun_reg;
  assign run_len     = run_len_reg;
  assign stuff_count = stuff_count_reg;

endmodule

// File: tb/tb_can_bit_stuffer.sv
// ---------------------------------------------------------------------------
// tb_can_bit_stuffer
//
// Self-checking bench for can_bit_stuffer. A behavioural model is stepped
// once per clock and compared against every output. A separate scoreboard
// checks that data bits leave in the order they were accepted. Directed
// scenarios check their TX / stuff / run-length sequences against constants.
// ---------------------------------------------------------------------------
module tb_can_bit_stuffer;

  localparam int STUFF_LEN = 5;
  localparam int CNT_W     = 8;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             tx_point = 1'b0;
  logic             stuff_en = 1'b0;
  logic             bit_valid = 1'b0;
  logic             bit_in = 1'b0;
  logic             bit_ready;
  logic             tx;
  logic             stuff_bit;
  logic             underrun;
  logic [2:0]       run_len;
  logic [CNT_W-1:0] stuff_count;

  can_bit_stuffer #(.STUFF_LEN(STUFF_LEN), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset), .tx_point(tx_point), .stuff_en(stuff_en),
    .bit_valid(bit_valid), .bit_in(bit_in), .bit_ready(bit_ready), .TX(tx),
    .stuff_bit(stuff_bit), .underrun(underrun), .run_len(run_len),
    .stuff_count(stuff_count)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  int m_run, m_cnt;
  bit m_last, m_pend, m_have, m_hb, m_tx, m_sb, m_ur, m_en_d;
  bit data_q[$];

  // Per-strobe log used by the directed scenarios
  int lg_tx[$], lg_sb[$], lg_ur[$], lg_run[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_cnt = 0; m_last = 1; m_pend = 0; m_have = 0; m_hb = 1;
    m_tx = 1; m_sb = 0; m_ur = 0; m_en_d = 0;
    data_q.delete();
  endtask

  task automatic clear_log();
    lg_tx.delete(); lg_sb.delete(); lg_ur.delete(); lg_run.delete();
  endtask

  // One clock: drive inputs, advance the model by the behavioural rules,
  // then compare all outputs 1 time unit after the edge.
  task automatic step(input bit rst, input bit tp, input bit en, input bit v, input bit b);
    bit fill;
    bit exp_bit;
    reset = rst; tx_point = tp; stuff_en = en; bit_valid = v; bit_in = b;
    @(posedge clock);
    if (rst) begin
      model_reset();
    end else begin
      fill = v && !m_have;
      m_sb = 0;
      m_ur = 0;
      if (en && !m_en_d) m_cnt = 0;
      if (tp) begin
        if (m_pend) begin
          m_last = !m_last;
          m_tx   = m_last;
          m_run  = 1;
          m_pend = 0;
          m_sb   = 1;
          if (m_cnt < CNT_MAX) m_cnt++;
        end else if (m_have) begin
          m_tx   = m_hb;
          m_have = 0;
          if (en) begin
            m_run  = (m_run != 0 && m_hb == m_last) ? m_run + 1 : 1;
            m_pend = (m_run == STUFF_LEN);
          end else begin
            m_run = 0;
          end
          m_last = m_hb;
        end else begin
          m_tx   = 1;
          m_ur   = 1;
          if (en) m_run = 0;
          m_last = 1;
        end
      end
      m_en_d = en;
      if (fill) begin
        m_have = 1;
        m_hb   = b;
        data_q.push_back(b);
      end
    end
    #1;
    chk("bit_ready", bit_ready, !m_have);
    chk("tx", tx, m_tx);
    chk("stuff_bit", stuff_bit, m_sb);
    chk("underrun", underrun, m_ur);
    chk("run_len", run_len, m_run);
    chk("stuff_count", stuff_count, m_cnt);
    chk("run_bound", run_len <= STUFF_LEN, 1);
    if (tp && !rst) begin
      lg_tx.push_back(tx);
      lg_sb.push_back(stuff_bit);
      lg_ur.push_back(underrun);
      lg_run.push_back(run_len);
      if (!stuff_bit && !underrun) begin
        if (data_q.size() == 0) begin
          chk("data_order_empty", 1, 0);
        end else begin
          exp_bit = data_q.pop_front();
          chk("data_order", tx, exp_bit);
        end
      end
    end
  endtask

  task automatic do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
  endtask

  // Offers bits in order, one strobe every `gap` cycles. It returns once all
  // bits are accepted and the buffer has drained. With wait_pend set, it also
  // waits for any pending stuff bit to go out.
  task automatic send_bits(input bit bits[$], input bit en, input int gap,
                           input bit wait_pend, input bit rand_valid);
    int idx = 0;
    int cyc = 0;
    bit pre, v, b;
    while (1) begin
      if (idx >= bits.size() && bit_ready && !(wait_pend && m_pend)) break;
      if (cyc > 20000) begin
        chk("send_timeout", 0, 1);
        break;
      end
      v   = (idx < bits.size()) && (!rand_valid || $urandom_range(3) != 0);
      b   = v ? bits[idx] : 1'b0;
      pre = bit_ready;
      step(0, (cyc % gap) == gap - 1, en, v, b);
      if (v && pre) idx++;
      cyc++;
    end
  endtask

  task automatic chk_log(input string tag, input int e_tx[$], input int e_sb[$]);
    chk({tag, "_len"}, lg_tx.size(), e_tx.size());
    for (int i = 0; i < e_tx.size(); i++) begin
      if (i < lg_tx.size()) begin
        chk({tag, "_tx"}, lg_tx[i], e_tx[i]);
        chk({tag, "_sb"}, lg_sb[i], e_sb[i]);
      end
    end
  endtask

  initial begin
    bit seq[$];
    int e_tx[$], e_sb[$], e_run[$];
    bit prev;
    int len, gap;

    model_reset();
    do_reset();
    chk("reset_tx", tx, 1);
    chk("reset_ready", bit_ready, 1);
    chk("reset_run", run_len, 0);
    chk("reset_cnt", stuff_count, 0);

    // Idle strobes with no data: recessive line, underrun each strobe
    clear_log();
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
    end
    e_tx = '{1, 1, 1, 1}; e_sb = '{0, 0, 0, 0};
    chk_log("idle", e_tx, e_sb);
    for (int i = 0; i < lg_ur.size(); i++) chk("idle_ur", lg_ur[i], 1);

    // 0,0,0,0,0,1 -> stuff 1 after the fifth zero
    do_reset();
    clear_log();
    seq = '{0, 0, 0, 0, 0, 1};
    send_bits(seq, 1, 3, 1, 0);
    e_tx = '{0, 0, 0, 0, 0, 1, 1}; e_sb = '{0, 0, 0, 0, 0, 1, 0};
    chk_log("five0", e_tx, e_sb);
    chk("five0_cnt", stuff_count, 1);

    // Ten zeros -> two stuff bits, the stuff bit starts a new run
    do_reset();
    clear_log();
    seq = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    send_bits(seq, 1, 3, 1, 0);
    e_tx = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    e_sb = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
    chk_log("ten0", e_tx, e_sb);
    chk("ten0_cnt", stuff_count, 2);

    // 1,1,1,1,1,0,0,0,0 -> stuff 0, then a second stuff left pending
    do_reset();
    clear_log();
    seq = '{1, 1, 1, 1, 1, 0, 0, 0, 0};
    send_bits(seq, 1, 3, 0, 0);
    e_tx  = '{1, 1, 1, 1, 1, 0, 0, 0, 0, 0};
    e_sb  = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    e_run = '{1, 2, 3, 4, 5, 1, 2, 3, 4, 5};
    chk_log("ones", e_tx, e_sb);
    for (int i = 0; i < e_run.size() && i < lg_run.size(); i++) chk("ones_run", lg_run[i], e_run[i]);

    // Reset while a stuff bit is pending and the buffer is full
    step(0, 0, 1, 1, 0);
    chk("pre_rst_full", bit_ready, 0);
    step(1, 0, 1, 0, 0);
    chk("rst_mid_tx", tx, 1);
    chk("rst_mid_ready", bit_ready, 1);
    chk("rst_mid_run", run_len, 0);
    chk("rst_mid_cnt", stuff_count, 0);
    step(0, 1, 0, 0, 0);
    chk("rst_mid_ur", underrun, 1);
    chk("rst_mid_sb", stuff_bit, 0);

    // Window closes with a stuff bit pending: it is still sent, and later
    // bits go out unstuffed
    do_reset();
    seq = '{0, 0, 0, 0, 0};
    send_bits(seq, 1, 3, 0, 0);
    clear_log();
    seq = '{1, 1, 1, 1, 1, 1, 1};
    send_bits(seq, 0, 3, 1, 0);
    e_tx = '{1, 1, 1, 1, 1, 1, 1, 1}; e_sb = '{1, 0, 0, 0, 0, 0, 0, 0};
    chk_log("close", e_tx, e_sb);
    chk("close_run", run_len, 0);
    chk("close_cnt_held", stuff_count, 1);

    // Long dominant frame: the stuff counter saturates
    do_reset();
    seq.delete();
    for (int i = 0; i < 1400; i++) seq.push_back(1'b0);
    send_bits(seq, 1, 2, 1, 0);
    chk("sat_cnt", stuff_count, CNT_MAX);

    // Randomized frames: run-biased bits, random strobe spacing and valid gaps
    for (int f = 0; f < 12; f++) begin
      for (int i = 0; i < 4; i++) step(0, $urandom_range(1), 0, 0, 0);
      seq.delete();
      prev = 1'($urandom_range(1));
      len  = $urandom_range(20, 60);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(9) < 3) prev = !prev;
        seq.push_back(prev);
      end
      gap = $urandom_range(1, 4);
      send_bits(seq, 1, gap, 1'($urandom_range(1)), 1);
      seq.delete();
      for (int i = 0; i < 4; i++) seq.push_back(1'($urandom_range(1)));
      send_bits(seq, 0, gap, 1, 1);
      if (f == 7) begin
        step(0, 0, 1, 1, 1);
        step(1, 1, 1, 0, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
